// File: rtl/item_rr_arbiter_if.sv
// Shared item channel between one producer and downstream consumers.
// The arbiter drives item through the producer modport.
interface myiface #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] item;

    modport producer (
        output item
    );

    modport consumer (
        input item
    );
endinterface

// File: rtl/item_rr_arbiter.sv
// Round-robin arbiter that latches one requester's item onto a shared
// channel for HOLD cycles, then re-arbitrates with no bubble.
module item_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 3,
    parameter int HOLD  = 2,
    localparam int IW   = $clog2(NREQ),
    localparam int CW   = (HOLD > 1) ? $clog2(HOLD) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_item,
    output logic [NREQ-1:0]       ack,
    output logic                  item_valid,
    output logic [IW-1:0]         gnt_id,
    output logic                  busy,
    myiface.producer              prod
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_q;
    logic [IW-1:0]     ptr_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  item_q;
    logic              valid_q;
    logic [NREQ-1:0]   ack_q;
    logic [IW-1:0]     gnt_q;

    logic [IW-1:0]     win_d;
    logic              found_d;
    logic [IW:0]       sum_d;
    logic [IW-1:0]     ptr_d;
    logic [WIDTH-1:0]  item_d;
    logic              last_d;
    logic              grant_d;

    // Search from ptr upward, wrapping; first requester found wins.
    always_comb begin
        win_d   = '0;
        found_d = 1'b0;
        sum_d   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum_d = {1'b0, ptr_q} + (IW+1)'(k);
            if (sum_d >= (IW+1)'(NREQ)) begin
                sum_d = sum_d - (IW+1)'(NREQ);
            end
            if (!found_d && req[sum_d[IW-1:0]]) begin
                found_d = 1'b1;
                win_d   = sum_d[IW-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = (win_d == IW'(NREQ-1)) ? '0 : win_d + IW'(1);
    end

    always_comb begin
        item_d = req_item[int'(win_d)*WIDTH +: WIDTH];
    end

    always_comb begin
        last_d  = (cnt_q == CW'(HOLD-1));
        grant_d = found_d && ((state_q == IDLE) || last_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            item_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= '0;
            gnt_q   <= '0;
        end else if (grant_d) begin
            state_q <= GRANT;
            ptr_q   <= ptr_d;
            cnt_q   <= '0;
            item_q  <= item_d;
            valid_q <= 1'b1;
            ack_q   <= NREQ'(1) << win_d;
            gnt_q   <= win_d;
        end else if (state_q == GRANT) begin
            ack_q <= '0;
            if (last_d) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign prod.item  = item_q;
    assign item_valid = valid_q;
    assign ack        = ack_q;
    assign gnt_id     = gnt_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_item_rr_arbiter.sv
// Directed bench for item_rr_arbiter with a queue-based scoreboard.
module tb_item_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] req_item;
    logic [3:0]  ack;
    logic        item_valid;
    logic [1:0]  gnt_id;
    logic        busy;

    myiface #(.WIDTH(3)) ifc ();

    item_rr_arbiter #(.NREQ(4), .WIDTH(3), .HOLD(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_item   (req_item),
        .ack        (ack),
        .item_valid (item_valid),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .prod       (ifc.producer)
    );

    typedef struct {
        logic [3:0] ack;
        logic [1:0] g;
        logic [2:0] it;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req_v);
        n_cmp++;
        if (act != req_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, req_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [1:0] g,
                        input logic [2:0] it);
        exp_t e;
        e.ack = a;
        e.g   = g;
        e.it  = it;
        exp_q.push_back(e);
    endtask

    // Grant: one ack cycle followed by one plain hold cycle.
    task automatic push_grant(input int g, input int it);
        push(4'(1 << g), 2'(g), 3'(it));
        push(4'b0000, 2'(g), 3'(it));
    endtask

    always @(negedge clk) begin
        if (rst_n && item_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: gnt %0d item %0d, none expected",
                         gnt_id, ifc.item);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_ack", int'(ack), int'(e.ack));
                chk("mon_gnt", int'(gnt_id), int'(e.g));
                chk("mon_item", int'(ifc.item), int'(e.it));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        req      = 4'b0000;
        req_item = {3'd4, 3'd3, 3'd2, 3'd1};

        // 1. Reset then idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(item_valid), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_item", int'(ifc.item), 0);
        chk("rst_gnt", int'(gnt_id), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_valid", int'(item_valid), 0);
            chk("idle_busy", int'(busy), 0);
        end

        // 2. Single request from requester 2
        req_item[6 +: 3] = 3'd5;
        req = 4'b0100;
        push_grant(2, 5);
        tick();
        chk("single_busy", int'(busy), 1);
        req = 4'b0000;
        tick();
        tick();
        chk("single_idle_valid", int'(item_valid), 0);
        chk("single_idle_busy", int'(busy), 0);
        chk("single_keep_gnt", int'(gnt_id), 2);
        chk("single_keep_item", int'(ifc.item), 5);

        // 4. Wrap from ptr=3: grant 0 then 1
        req_item = {3'd4, 3'd3, 3'd2, 3'd1};
        req = 4'b0011;
        push_grant(0, 1);
        push_grant(1, 2);
        tick();
        req = 4'b0010;
        tick();
        tick();
        req = 4'b0000;
        tick();
        tick();
        chk("wrap_idle_busy", int'(busy), 0);

        // 3. Full contention after reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 4'b1111;
        push_grant(0, 1);
        push_grant(1, 2);
        push_grant(2, 3);
        push_grant(3, 4);
        push_grant(0, 1);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("full_nobubble", int'(item_valid), 1);
            if (i == 9) req = 4'b0000;
        end
        tick();
        chk("full_end_valid", int'(item_valid), 0);

        // 5. Mid-hold changes ignored (ptr=1 now)
        req_item[3 +: 3] = 3'd3;
        req = 4'b0010;
        push_grant(1, 3);
        tick();
        req_item[3 +: 3] = 3'd7;
        req = 4'b0000;
        tick();
        chk("midhold_item", int'(ifc.item), 3);
        tick();
        chk("midhold_idle", int'(busy), 0);

        // 6. Async reset mid-hold, then arbitration restarts at 0
        req_item = {3'd4, 3'd3, 3'd2, 3'd1};
        req = 4'b0010;
        tick();
        req = 4'b0000;
        chk("pre_rst_ack", int'(ack), 2);
        chk("pre_rst_valid", int'(item_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", int'(item_valid), 0);
        chk("async_ack", int'(ack), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_item", int'(ifc.item), 0);
        #1;
        rst_n = 1'b1;
        req = 4'b1001;
        push_grant(0, 1);
        tick();
        req = 4'b0000;
        repeat (3) tick();
        chk("post_rst_busy", int'(busy), 0);

        chk("queue_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
